// File: rtl/cl_axi_sram_rsp.sv
// cl_axi_sram_rsp
//   AXI4 slave that answers the memory DUT's master port from an on-chip
//   SRAM, so the DUT can run without DDR. Bursts are INCR only. The write
//   and read channels are independent FSMs, each with one burst in flight.
//   The SRAM has one write port (write channel) and one read port (read
//   channel). A same-cycle read and write of one word returns the old data.
// Ports
//   clk, pipe_rst_n             clock, asynchronous active-low reset
//   aw*/awvalid/awready         write address channel
//   wdata/wstrb/wlast/wvalid/wready  write data channel
//   bid/bresp/bvalid/bready     write response channel
//   ar*/arvalid/arready         read address channel
//   rid/rdata/rresp/rlast/rvalid/rready  read data channel
module cl_axi_sram_rsp #(
   parameter int DATA_WIDTH = 256,
   parameter int ID_WIDTH   = 8,
   parameter int ADDR_WIDTH = 40,
   parameter int LEN_WIDTH  = 4,
   parameter int MEM_DEPTH  = 1024
) (
   input  logic                    clk,
   input  logic                    pipe_rst_n,
   input  logic [ID_WIDTH-1:0]     awid,
   input  logic [ADDR_WIDTH-1:0]   awaddr,
   input  logic [LEN_WIDTH-1:0]    awlen,
   input  logic [2:0]              awsize,
   input  logic                    awvalid,
   output logic                    awready,
   input  logic [DATA_WIDTH-1:0]   wdata,
   input  logic [DATA_WIDTH/8-1:0] wstrb,
   input  logic                    wlast,
   input  logic                    wvalid,
   output logic                    wready,
   output logic [ID_WIDTH-1:0]     bid,
   output logic [1:0]              bresp,
   output logic                    bvalid,
   input  logic                    bready,
   input  logic [ID_WIDTH-1:0]     arid,
   input  logic [ADDR_WIDTH-1:0]   araddr,
   input  logic [LEN_WIDTH-1:0]    arlen,
   input  logic [2:0]              arsize,
   input  logic                    arvalid,
   output logic                    arready,
   output logic [ID_WIDTH-1:0]     rid,
   output logic [DATA_WIDTH-1:0]   rdata,
   output logic [1:0]              rresp,
   output logic                    rlast,
   output logic                    rvalid,
   input  logic                    rready
);

   localparam int STRB_WIDTH = DATA_WIDTH / 8;
   localparam int OB         = $clog2(STRB_WIDTH);
   localparam int IW         = $clog2(MEM_DEPTH);
   localparam int HI_WIDTH   = ADDR_WIDTH - OB - IW;
   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   // A burst is in error when it addresses beyond the SRAM or uses a
   // transfer size other than the full bus width.
   function automatic logic burst_err(input logic [ADDR_WIDTH-1:0] addr,
                                      input logic [2:0]            size);
      return (addr[ADDR_WIDTH-1:OB+IW] != {HI_WIDTH{1'b0}}) || (size != 3'(OB));
   endfunction

   typedef enum logic [1:0] {W_IDLE = 2'd0, W_DATA = 2'd1, W_RESP = 2'd2} wstate_t;
   typedef enum logic [1:0] {R_IDLE = 2'd0, R_FETCH = 2'd1, R_DATA = 2'd2} rstate_t;

   logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

   wstate_t              wstate_r;
   logic [IW-1:0]        widx_r;
   logic [LEN_WIDTH-1:0] wlen_r;
   logic [LEN_WIDTH-1:0] wcnt_r;
   logic                 werr_r;
   logic                 wover_r;   // sticky: a beat past awlen+1 arrived without wlast
   logic                 w_hs_s;
   logic                 wen_s;

   rstate_t              rstate_r;
   logic [IW-1:0]        ridx_r;
   logic [LEN_WIDTH-1:0] rlen_r;
   logic [LEN_WIDTH-1:0] rcnt_r;
   logic                 rerr_r;
   logic                 ren_s;
   logic [IW-1:0]        raddr_s;

   // Low byte-offset address bits carry no information for a full-width bus.
   logic unused_s;
   assign unused_s = ^{awaddr[OB-1:0], araddr[OB-1:0]};

   assign w_hs_s = wvalid && wready;
   assign wen_s  = w_hs_s && !werr_r;

   // Write channel FSM: AW acceptance, beat counting and B response.
   always_ff @(posedge clk or negedge pipe_rst_n) begin
      if (!pipe_rst_n) begin
         wstate_r <= W_IDLE;
         awready  <= 1'b0;
         wready   <= 1'b0;
         bvalid   <= 1'b0;
         bid      <= {ID_WIDTH{1'b0}};
         bresp    <= RESP_OKAY;
         widx_r   <= {IW{1'b0}};
         wlen_r   <= {LEN_WIDTH{1'b0}};
         wcnt_r   <= {LEN_WIDTH{1'b0}};
         werr_r   <= 1'b0;
         wover_r  <= 1'b0;
      end else begin
         case (wstate_r)
            W_IDLE: begin
               if (awvalid && awready) begin
                  bid      <= awid;
                  widx_r   <= awaddr[OB +: IW];
                  wlen_r   <= awlen;
                  werr_r   <= burst_err(awaddr, awsize);
                  wcnt_r   <= {LEN_WIDTH{1'b0}};
                  wover_r  <= 1'b0;
                  awready  <= 1'b0;
                  wready   <= 1'b1;
                  wstate_r <= W_DATA;
               end else begin
                  awready  <= 1'b1;
               end
            end
            W_DATA: begin
               if (w_hs_s) begin
                  widx_r <= widx_r + 1'b1;   // wraps modulo MEM_DEPTH
                  if (wlast) begin
                     wready   <= 1'b0;
                     bvalid   <= 1'b1;
                     bresp    <= (werr_r || wover_r || (wcnt_r != wlen_r)) ? RESP_SLVERR : RESP_OKAY;
                     wstate_r <= W_RESP;
                  end else begin
                     if (wcnt_r == wlen_r) begin
                        wover_r <= 1'b1;
                     end
                     wcnt_r <= wcnt_r + 1'b1;
                  end
               end
            end
            W_RESP: begin
               if (bready) begin
                  bvalid   <= 1'b0;
                  awready  <= 1'b1;
                  wstate_r <= W_IDLE;
               end
            end
            default: begin
               wstate_r <= W_IDLE;
               awready  <= 1'b0;
               wready   <= 1'b0;
               bvalid   <= 1'b0;
            end
         endcase
      end
   end

   // Read enable: first word in R_FETCH, next word on each non-last R handshake.
   always_comb begin
      ren_s   = 1'b0;
      raddr_s = ridx_r;
      if (rstate_r == R_FETCH) begin
         ren_s   = 1'b1;
      end else if ((rstate_r == R_DATA) && rready && !rlast) begin
         ren_s   = 1'b1;
         raddr_s = ridx_r + 1'b1;
      end else begin
         ren_s   = 1'b0;
      end
   end

   // Read channel FSM: AR acceptance, beat sequencing and R handshakes.
   always_ff @(posedge clk or negedge pipe_rst_n) begin
      if (!pipe_rst_n) begin
         rstate_r <= R_IDLE;
         arready  <= 1'b0;
         rvalid   <= 1'b0;
         rlast    <= 1'b0;
         rid      <= {ID_WIDTH{1'b0}};
         rresp    <= RESP_OKAY;
         ridx_r   <= {IW{1'b0}};
         rlen_r   <= {LEN_WIDTH{1'b0}};
         rcnt_r   <= {LEN_WIDTH{1'b0}};
         rerr_r   <= 1'b0;
      end else begin
         case (rstate_r)
            R_IDLE: begin
               if (arvalid && arready) begin
                  rid      <= arid;
                  ridx_r   <= araddr[OB +: IW];
                  rlen_r   <= arlen;
                  rerr_r   <= burst_err(araddr, arsize);
                  rcnt_r   <= {LEN_WIDTH{1'b0}};
                  arready  <= 1'b0;
                  rstate_r <= R_FETCH;
               end else begin
                  arready  <= 1'b1;
               end
            end
            R_FETCH: begin
               rvalid   <= 1'b1;
               rlast    <= (rlen_r == {LEN_WIDTH{1'b0}});
               rresp    <= rerr_r ? RESP_SLVERR : RESP_OKAY;
               rstate_r <= R_DATA;
            end
            R_DATA: begin
               if (rready) begin
                  if (rlast) begin
                     rvalid   <= 1'b0;
                     rlast    <= 1'b0;
                     arready  <= 1'b1;
                     rstate_r <= R_IDLE;
                  end else begin
                     ridx_r <= ridx_r + 1'b1;
                     rcnt_r <= rcnt_r + 1'b1;
                     rlast  <= ((rcnt_r + 1'b1) == rlen_r);
                  end
               end
            end
            default: begin
               rstate_r <= R_IDLE;
               arready  <= 1'b0;
               rvalid   <= 1'b0;
               rlast    <= 1'b0;
            end
         endcase
      end
   end

   // SRAM write port with byte enables; errored bursts never write.
   always_ff @(posedge clk) begin
      if (wen_s) begin
         for (int b = 0; b < STRB_WIDTH; b++) begin
            if (wstrb[b]) begin
               mem[widx_r][b*8 +: 8] <= wdata[b*8 +: 8];
            end
         end
      end
   end

   // SRAM read port. rdata is only meaningful with rvalid, so it has no
   // reset; holding ren_s low while stalled keeps the beat stable.
   always_ff @(posedge clk) begin
      if (ren_s) begin
         rdata <= rerr_r ? {DATA_WIDTH{1'b0}} : mem[raddr_s];
      end
   end

endmodule

// File: tb/tb_cl_axi_sram_rsp.sv
module tb_cl_axi_sram_rsp;

   localparam int DW = 256;
   localparam int D  = 1024;

   logic            clk;
   logic            pipe_rst_n;
   logic [7:0]      awid, arid, bid, rid;
   logic [39:0]     awaddr, araddr;
   logic [3:0]      awlen, arlen;
   logic [2:0]      awsize, arsize;
   logic            awvalid, awready, arvalid, arready;
   logic [DW-1:0]   wdata, rdata;
   logic [DW/8-1:0] wstrb;
   logic            wlast, wvalid, wready;
   logic [1:0]      bresp, rresp;
   logic            bvalid, bready, rlast, rvalid, rready;

   cl_axi_sram_rsp dut (
      .clk(clk), .pipe_rst_n(pipe_rst_n),
      .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize),
      .awvalid(awvalid), .awready(awready),
      .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
      .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
      .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
      .arvalid(arvalid), .arready(arready),
      .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
   );

   typedef struct {logic [7:0] id; logic [DW-1:0] data; logic [1:0] resp; logic last;} rbeat_t;
   typedef struct {logic [7:0] id; logic [1:0] resp;} bexp_t;

   logic [DW-1:0] model_mem [D];
   rbeat_t        exp_r [$];
   bexp_t         exp_b [$];
   logic [DW-1:0] wd [32];
   logic [31:0]   ws [32];

   int  n_checks = 0;
   int  n_errors = 0;
   int  cyc = 0;
   int  last_aw_cyc, last_ar_cyc, b_rise, r_rise, run_len, last_run;
   bit  prev_b, prev_r, bp_rand;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial forever begin
      @(posedge clk);
      cyc = cyc + 1;
   end

   task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Ready backpressure on B and R: always ready, or random per cycle.
   initial begin
      rready = 1'b0;
      bready = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         if (bp_rand) begin
            rready = 1'($urandom_range(0, 1));
            bready = 1'($urandom_range(0, 1));
         end else begin
            rready = 1'b1;
            bready = 1'b1;
         end
      end
   end

   // Compare process: every valid cycle is checked against the queue head;
   // the head only advances on a handshake, so stalls must hold values.
   initial forever begin
      @(negedge clk);
      if (pipe_rst_n) begin
         if (bvalid) begin
            if (exp_b.size() == 0) begin
               check("b_unexpected", 1'b1, 1'b0);
            end else begin
               check("bid", bid, exp_b[0].id);
               check("bresp", bresp, exp_b[0].resp);
               if (bready) void'(exp_b.pop_front());
            end
         end
         if (rvalid) begin
            if (exp_r.size() == 0) begin
               check("r_unexpected", 1'b1, 1'b0);
            end else begin
               check("rid", rid, exp_r[0].id);
               check("rdata", rdata, exp_r[0].data);
               check("rresp", rresp, exp_r[0].resp);
               check("rlast", rlast, exp_r[0].last);
               if (rready) void'(exp_r.pop_front());
            end
         end
      end
      if (bvalid && !prev_b) b_rise = cyc;
      if (rvalid && !prev_r) r_rise = cyc;
      if (rvalid) begin
         run_len++;
      end else begin
         if (run_len > 0) last_run = run_len;
         run_len = 0;
      end
      prev_b = bvalid;
      prev_r = rvalid;
   end

   // which: 0 awready, 1 arready, 2 wready, 3 awready&&arready
   task automatic wait_sig(input int which, input string name, output int hs_cyc);
      bit ok = 1'b0;
      hs_cyc = 0;
      for (int t = 0; t < 200; t++) begin
         @(negedge clk);
         if ((which == 0 && awready) || (which == 1 && arready) ||
             (which == 2 && wready) || (which == 3 && awready && arready)) begin
            ok = 1'b1;
            hs_cyc = cyc;
            break;
         end
      end
      check(name, ok, 1'b1);
   endtask

   task automatic do_write(input logic [7:0] id, input logic [39:0] addr, input logic [3:0] len,
                           input logic [2:0] size, input int nbeats);
      logic err;
      int   idx, hc;
      err = ((addr >> 15) != 40'd0) || (size != 3'd5);
      idx = int'(addr[14:5]);
      for (int i = 0; i < nbeats; i++)
         if (!err)
            for (int b = 0; b < 32; b++)
               if (ws[i][b]) model_mem[(idx + i) % D][b*8 +: 8] = wd[i][b*8 +: 8];
      exp_b.push_back('{id, (err || nbeats != int'(len) + 1) ? 2'b10 : 2'b00});
      @(posedge clk);
      #1;
      awid = id; awaddr = addr; awlen = len; awsize = size; awvalid = 1'b1;
      wait_sig(0, "aw_hs", hc);
      last_aw_cyc = hc;
      @(posedge clk);
      #1;
      awvalid = 1'b0;
      for (int i = 0; i < nbeats; i++) begin
         wvalid = 1'b1; wdata = wd[i]; wstrb = ws[i]; wlast = (i == nbeats - 1);
         wait_sig(2, "w_hs", hc);
         @(posedge clk);
         #1;
      end
      wvalid = 1'b0;
      wlast  = 1'b0;
   endtask

   task automatic do_read(input logic [7:0] id, input logic [39:0] addr, input logic [3:0] len,
                          input logic [2:0] size);
      logic err;
      int   idx, hc;
      err = ((addr >> 15) != 40'd0) || (size != 3'd5);
      idx = int'(addr[14:5]);
      for (int i = 0; i <= int'(len); i++)
         exp_r.push_back('{id, err ? {DW{1'b0}} : model_mem[(idx + i) % D],
                          err ? 2'b10 : 2'b00, (i == int'(len))});
      @(posedge clk);
      #1;
      arid = id; araddr = addr; arlen = len; arsize = size; arvalid = 1'b1;
      wait_sig(1, "ar_hs", hc);
      last_ar_cyc = hc;
      @(posedge clk);
      #1;
      arvalid = 1'b0;
   endtask

   // AW and AR taken together; the single W beat lands in the same cycle
   // the read fetches the same word, so the read must see the old value.
   task automatic do_concurrent(input logic [7:0] wid_i, input logic [7:0] rid_i,
                                input logic [39:0] addr, input logic [DW-1:0] data);
      int idx, hc;
      idx = int'(addr[14:5]);
      exp_r.push_back('{rid_i, model_mem[idx], 2'b00, 1'b1});
      model_mem[idx] = data;
      exp_b.push_back('{wid_i, 2'b00});
      @(posedge clk);
      #1;
      awid = wid_i; awaddr = addr; awlen = 4'd0; awsize = 3'd5; awvalid = 1'b1;
      arid = rid_i; araddr = addr; arlen = 4'd0; arsize = 3'd5; arvalid = 1'b1;
      wait_sig(3, "awar_hs", hc);
      @(posedge clk);
      #1;
      awvalid = 1'b0; arvalid = 1'b0;
      wvalid = 1'b1; wdata = data; wstrb = 32'hFFFF_FFFF; wlast = 1'b1;
      wait_sig(2, "w_hs", hc);
      @(posedge clk);
      #1;
      wvalid = 1'b0; wlast = 1'b0;
   endtask

   task automatic drain();
      bit ok = 1'b0;
      for (int t = 0; t < 400; t++) begin
         @(negedge clk);
         if (exp_b.size() == 0 && exp_r.size() == 0) begin
            ok = 1'b1;
            break;
         end
      end
      check("drain_timeout", ok, 1'b1);
      exp_b.delete();
      exp_r.delete();
      repeat (2) @(negedge clk);
   endtask

   initial begin
      pipe_rst_n = 1'b0; bp_rand = 1'b0;
      awvalid = 1'b0; arvalid = 1'b0; wvalid = 1'b0; wlast = 1'b0;
      awid = 8'd0; awaddr = 40'd0; awlen = 4'd0; awsize = 3'd0;
      arid = 8'd0; araddr = 40'd0; arlen = 4'd0; arsize = 3'd0;
      wdata = {DW{1'b0}}; wstrb = 32'd0;
      run_len = 0; last_run = 0; b_rise = 0; r_rise = 0;
      for (int i = 0; i < D; i++) model_mem[i] = {DW{1'b0}};

      // Reset state and ready release timing
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_ctrl", {awready, wready, bvalid, arready, rvalid, rlast}, 6'b0);
      check("rst_ids", {bid, bresp, rid, rresp}, 20'b0);
      @(posedge clk);
      #1;
      pipe_rst_n = 1'b1;
      @(negedge clk);
      check("pre_edge_ready", {awready, arready}, 2'b00);
      @(negedge clk);
      check("idle_ready", {awready, arready, wready}, 3'b110);

      // Single beat write/read at 0x40
      for (int i = 0; i < 32; i++) ws[i] = 32'hFFFF_FFFF;
      wd[0] = {32{8'hA5}};
      do_write(8'h3C, 40'h40, 4'd0, 3'd5, 1);
      drain();
      check("model_word2", model_mem[2], {32{8'hA5}});
      check("aw_to_b", 32'(b_rise - last_aw_cyc), 32'd2);
      do_read(8'h5A, 40'h40, 4'd0, 3'd5);
      drain();
      check("ar_to_r", 32'(r_rise - last_ar_cyc), 32'd2);

      // 16-beat bursts with a partial strobe on beat 3
      for (int i = 0; i < 16; i++) wd[i] = {32{8'hEE}};
      do_write(8'h01, 40'h0, 4'd15, 3'd5, 16);
      drain();
      for (int i = 0; i < 16; i++) begin
         wd[i] = {32{8'(i)}};
         ws[i] = (i == 3) ? 32'h0000_FFFF : 32'hFFFF_FFFF;
      end
      do_write(8'h02, 40'h0, 4'd15, 3'd5, 16);
      drain();
      check("model_word3", model_mem[3], {{16{8'hEE}}, {16{8'h03}}});
      for (int i = 0; i < 32; i++) ws[i] = 32'hFFFF_FFFF;
      do_read(8'h03, 40'h0, 4'd15, 3'd5);
      drain();
      check("r_burst_run", 32'(last_run), 32'd16);

      // Index wrap at the top of the SRAM
      for (int i = 0; i < 4; i++) wd[i] = {32{8'(8'h10 + i)}};
      do_write(8'h04, 40'h7FC0, 4'd3, 3'd5, 4);
      drain();
      check("model_word0_wrap", model_mem[0], {32{8'h12}});
      do_read(8'h05, 40'h0, 4'd3, 3'd5);
      do_read(8'h06, 40'h7FC0, 4'd3, 3'd5);
      drain();

      // Errors: out-of-range write dropped, wrong arsize read
      wd[0] = {32{8'hFF}};
      do_write(8'h07, 40'h8000, 4'd0, 3'd5, 1);
      drain();
      check("model_word0_kept", model_mem[0], {32{8'h12}});
      do_read(8'h08, 40'h0, 4'd0, 3'd5);
      do_read(8'h09, 40'h0, 4'd3, 3'd3);
      drain();

      // Early and late wlast under random backpressure
      bp_rand = 1'b1;
      for (int i = 0; i < 3; i++) wd[i] = {32{8'(8'h40 + i)}};
      do_write(8'h0A, 40'h200, 4'd3, 3'd5, 3);
      do_read(8'h0B, 40'h200, 4'd2, 3'd5);
      drain();
      for (int i = 0; i < 3; i++) wd[i] = {32{8'(8'h50 + i)}};
      do_write(8'h0C, 40'h280, 4'd1, 3'd5, 3);
      do_read(8'h0D, 40'h280, 4'd2, 3'd5);
      drain();
      check("model_word22_late", model_mem[22], {32{8'h52}});
      bp_rand = 1'b0;
      repeat (2) @(posedge clk);

      // Same-cycle read and write of word 5
      do_concurrent(8'h0E, 8'h0F, 40'hA0, {32{8'hC3}});
      drain();
      check("model_word5", model_mem[5], {32{8'hC3}});
      do_read(8'h10, 40'hA0, 4'd0, 3'd5);
      drain();

      // Reset in the middle of a read burst
      do_read(8'h11, 40'h0, 4'd15, 3'd5);
      repeat (3) @(posedge clk);
      #1;
      pipe_rst_n = 1'b0;
      exp_r.delete();
      @(negedge clk);
      check("rst_mid_rvalid", {rvalid, arready, awready}, 3'b000);
      @(posedge clk);
      #1;
      pipe_rst_n = 1'b1;
      @(negedge clk);
      check("rst_rel_pre_edge", {awready, arready}, 2'b00);
      @(negedge clk);
      check("rst_rel_ready", {awready, arready, rvalid}, 3'b110);
      do_read(8'h12, 40'h0, 4'd3, 3'd5);
      drain();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
